// File: rtl/input_thermometer_frame_encoder.sv
// Thermometer-encodes a valid/ready pixel stream into a shadow frame buffer and presents each
// completed frame as a held vector to the gate network, with a delayed valid for the classifier.
module input_thermometer_frame_encoder #(
  parameter int NUM_PIXELS       = 784,
  parameter int PIXEL_WIDTH      = 8,
  parameter int THERMO_BITS      = 3,
  parameter int HOLD_CYCLES      = 11,
  parameter int NET_TO_OUT_DELAY = 2,
  localparam int NET_IN_WIDTH    = NUM_PIXELS * THERMO_BITS
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [PIXEL_WIDTH-1:0]  pix_i,
  input  logic                    pix_valid_i,
  input  logic                    pix_last_i,
  output logic                    pix_ready_o,
  output logic [NET_IN_WIDTH-1:0] net_o,
  output logic                    net_valid_o,
  output logic                    net_valid_dly_o,
  output logic                    frame_err_o
);

  localparam int CNT_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  // Threshold k splits the pixel range into THERMO_BITS+1 equal bands.
  function automatic logic [PIXEL_WIDTH:0] thresh(input int k);
    thresh = (PIXEL_WIDTH + 1)'(((k + 1) << PIXEL_WIDTH) / (THERMO_BITS + 1));
  endfunction

  logic [CNT_W-1:0]        pix_cnt_r;
  logic [HOLD_W-1:0]       hold_cnt_r;
  logic [NET_IN_WIDTH-1:0] fill_r;
  logic [THERMO_BITS-1:0]  enc_s;
  logic [NET_IN_WIDTH-1:0] fill_next_s;
  logic [CNT_W-1:0]        cnt_next_s;
  logic [HOLD_W-1:0]       hold_next_s;
  logic                    xfer_s;
  logic                    complete_s;
  logic                    early_s;

  assign xfer_s     = pix_valid_i && pix_ready_o;
  assign complete_s = xfer_s && (pix_cnt_r == LAST_IDX);
  assign early_s    = xfer_s && pix_last_i && (pix_cnt_r != LAST_IDX);

  // Thermometer encoding of the current beat.
  always_comb begin
    enc_s = '0;
    for (int k = 0; k < THERMO_BITS; k++) begin
      enc_s[k] = ({1'b0, pix_i} >= thresh(k));
    end
  end

  // Next fill buffer, counter and hold values.
  always_comb begin
    fill_next_s = fill_r;
    for (int p = 0; p < NUM_PIXELS; p++) begin
      fill_next_s[p*THERMO_BITS +: THERMO_BITS] =
        (xfer_s && (pix_cnt_r == CNT_W'(p))) ? enc_s : fill_r[p*THERMO_BITS +: THERMO_BITS];
    end
    if (complete_s || early_s) begin
      cnt_next_s = CNT_ZERO;
    end else if (xfer_s) begin
      cnt_next_s = pix_cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = pix_cnt_r;
    end
    if (complete_s) begin
      hold_next_s = HOLD_INIT;
    end else if (hold_cnt_r != HOLD_ZERO) begin
      hold_next_s = hold_cnt_r - HOLD_ONE;
    end else begin
      hold_next_s = HOLD_ZERO;
    end
  end

  // Frame state; ready is registered from next-state so only the completing beat stalls.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pix_cnt_r   <= CNT_ZERO;
      hold_cnt_r  <= HOLD_ZERO;
      fill_r      <= '0;
      net_o       <= '0;
      net_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      pix_ready_o <= 1'b1;
    end else begin
      pix_cnt_r   <= cnt_next_s;
      hold_cnt_r  <= hold_next_s;
      fill_r      <= fill_next_s;
      net_valid_o <= complete_s;
      frame_err_o <= (complete_s && !pix_last_i) || early_s;
      pix_ready_o <= !((cnt_next_s == LAST_IDX) && (hold_next_s != HOLD_ZERO));
      if (complete_s) begin
        net_o <= fill_next_s;
      end
    end
  end

  generate
    if (NET_TO_OUT_DELAY == 0) begin : g_no_dly
      assign net_valid_dly_o = net_valid_o;
    end else if (NET_TO_OUT_DELAY == 1) begin : g_dly1
      // Single-stage delay of the frame valid.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          net_valid_dly_o <= 1'b0;
        end else begin
          net_valid_dly_o <= net_valid_o;
        end
      end
    end else begin : g_dlyn
      logic [NET_TO_OUT_DELAY-1:0] dly_r;
      // Shift register matching the network pipeline depth.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          dly_r <= '0;
        end else begin
          dly_r <= {dly_r[NET_TO_OUT_DELAY-2:0], net_valid_o};
        end
      end
      assign net_valid_dly_o = dly_r[NET_TO_OUT_DELAY-1];
    end
  endgenerate

endmodule
